ram_32x4_ctrl: RTL
==================

Name: ram_32x4_ctrl

Overview:
- Initiator-side controller for the team's 32x4 single-port RAM, which registers address, data and write enable at the clock edge and reads combinationally from the registered address.
- Accepts burst read and burst write commands from a host over a valid/ready handshake and drives the RAM's address, data and write-enable inputs from registers.
- Streams write data in with a per-beat handshake and streams read data out with last-beat marking; sits between the sequencing logic and the RAM instance.

Parameters:
- ADDR_W, 5, RAM address width; depth is 2**ADDR_W = 32.
- DATA_W, 4, RAM word width.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  command valid.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1 = burst write, 0 = burst read.
- req_addr  in  ADDR_W  start address.
- req_len  in  ADDR_W  beats minus 1 (0..31 gives 1..32 beats).
- wr_data  in  DATA_W  write beat data.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  high in WRITE state.
- rd_data  out  DATA_W  read beat data (registered).
- rd_valid  out  1  read beat valid, one cycle per beat, no backpressure.
- rd_last  out  1  qualifies the final read beat.
- busy  out  1  high whenever state is not IDLE.
- ram_address  out  ADDR_W  registered, to RAM address.
- ram_data_in  out  DATA_W  registered, to RAM data_in.
- ram_write_enable  out  1  registered, to RAM write_enable.
- ram_data_out  in  DATA_W  from RAM data_out.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All outputs are 0 except req_ready, which is 1.
  - Beat counter, address counter and pipeline tags are cleared.
  - A reset mid-burst aborts the burst. No partial response follows.
  - ram_write_enable=0 at the first edge after reset clears the RAM's internal write register.
- States are IDLE, WRITE, READ and DRAIN.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge, latch addr=req_addr and cnt=req_len.
  - If req_write=1, go to WRITE with ram_write_enable held at 0.
  - If req_write=0, register ram_address=req_addr on that same edge as issue 0, set pipeline tag p1=1, and mark p1_last if req_len==0. Go to READ if req_len!=0, else go to DRAIN.
- WRITE:
  - wr_ready=1.
  - On wr_valid, register ram_address=addr, ram_data_in=wr_data and ram_write_enable=1, then addr+=1 (mod 32) and cnt-=1.
  - Cycles without wr_valid register ram_write_enable=0; the burst stalls with no timeout.
  - After the beat taken with cnt==0, go to IDLE.
  - The RAM commits each beat one edge after the controller registers it. The earliest following read address is registered one edge later still, so read-after-write returns the new data with no extra wait state.
- READ:
  - Each cycle, register ram_address=addr+1, addr+=1 (mod 32), cnt-=1 and p1=1.
  - p1_last=1 on the issue where cnt reaches 0; then go to DRAIN.
  - ram_write_enable=0 throughout.
- Read pipeline (2 stages):
  - p2<=p1 and p2_last<=p1_last at every edge; the RAM captures the address in this cycle.
  - At the next edge: rd_valid<=p2, rd_last<=p2_last, rd_data<=ram_data_out.
  - First rd_valid is 2 cycles after the accept edge. A burst of N beats gives N consecutive rd_valid cycles.
- DRAIN:
  - No issue; p1=0.
  - Go to IDLE on the edge that samples the last beat, so req_ready=1 in the same cycle rd_last=1.
- Boundaries:
  - Address wraps 31->0 inside a burst.
  - wr_valid outside WRITE is ignored, with no RAM write.
  - req_valid while busy is not accepted.
  - rd_data holds its last value when rd_valid=0.
  - A 32-beat burst touches every word exactly once.

Decomposition:
- Package ram_ctrl_pkg:
  - ADDR_W=5, DATA_W=4, DEPTH=32.
  - State enum {IDLE, WRITE, READ, DRAIN}.
- Sub-module ram_rd_pipe: the 2-stage valid/last tag shift plus the rd_data capture register.
- The FSM, counters and RAM output registers stay in the top module.

Test Plan:
- Write: req_addr=3, req_len=3, wr_data 1,2,3,4 back-to-back. Then read: req_addr=3, req_len=3. Required: rd_data 1,2,3,4 on 4 consecutive rd_valid cycles; first rd_valid 2 cycles after accept; rd_last on beat 4 only; req_ready=1 in that cycle.
- Wrap: write req_addr=30, req_len=3, data A,B,C,D; read single beats at 30, 31, 0, 1. Required: A, B, C, D; RAM writes occur only at addresses 30, 31, 0, 1.
- Stalls: write 4 beats with wr_valid low for 2 cycles between beats. Required: ram_write_enable pulses exactly 4 times; readback is correct; busy stays high until the 4th beat.
- Full burst: write req_len=31 with data=addr[3:0]; read req_len=31 from 0. Required: 32 rd_valid cycles with data 0..15,0..15; rd_last only on the 32nd.
- Busy: req_valid held high during a read burst. Required: the second command is accepted only in the rd_last cycle's IDLE edge; no beats are lost or duplicated.
- Reset mid-write after 2 of 4 beats. Required: all outputs return to reset values immediately and ram_write_enable=0; words already written remain in RAM; no rd_valid follows.

Source files
------------

// File: rtl/ram_32x4_ctrl_pkg.sv
// Shared constants and FSM state type for the 32x4 RAM controller.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
  } state_t;

endpackage

// File: rtl/ram_32x4_ctrl_if.sv
// Host-side command / write-stream / read-stream bundle for ram_32x4_ctrl.
interface ram_32x4_ctrl_if #(
  parameter int unsigned ADDR_W = ram_ctrl_pkg::ADDR_W,
  parameter int unsigned DATA_W = ram_ctrl_pkg::DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_len, wr_data, wr_valid,
    input  req_ready, wr_ready, rd_data, rd_valid, rd_last, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wr_data, wr_valid,
    output req_ready, wr_ready, rd_data, rd_valid, rd_last, busy
  );

endinterface

// File: rtl/ram_32x4_ctrl_rd_pipe.sv
// Read-return pipeline: stage-2 valid/last tags and the registered rd_data capture.
module ram_rd_pipe #(
  parameter int unsigned DATA_W = ram_ctrl_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_p1,
  input  logic              i_p1_last,
  input  logic [DATA_W-1:0] i_ram_data,
  output logic              o_p2_last,
  output logic              o_rd_valid,
  output logic              o_rd_last,
  output logic [DATA_W-1:0] o_rd_data
);

  logic              r_p2;
  logic              r_p2_last;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p2       <= 1'b0;
      r_p2_last  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_p2       <= i_p1;
      r_p2_last  <= i_p1_last;
      r_rd_valid <= r_p2;
      r_rd_last  <= r_p2_last;
      // Capture only on a live beat so rd_data holds between bursts.
      if (r_p2) r_rd_data <= i_ram_data;
    end
  end

  assign o_p2_last  = r_p2_last;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_last  = r_rd_last;
  assign o_rd_data  = r_rd_data;

endmodule

// File: rtl/ram_32x4_ctrl.sv
// Burst read/write controller for the 32x4 single-port RAM; drives the RAM
// inputs from registers and returns read data through a 2-stage tag pipeline.
module ram_32x4_ctrl #(
  parameter int unsigned ADDR_W = ram_ctrl_pkg::ADDR_W,
  parameter int unsigned DATA_W = ram_ctrl_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  ram_32x4_ctrl_if.slave    host,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_data_out
);

  import ram_ctrl_pkg::*;

  state_t            r_state,        w_state_nxt;
  logic [ADDR_W-1:0] r_addr,         w_addr_nxt;
  logic [ADDR_W-1:0] r_cnt,          w_cnt_nxt;
  logic [ADDR_W-1:0] r_ram_address,  w_ram_address_nxt;
  logic [DATA_W-1:0] r_ram_data_in,  w_ram_data_in_nxt;
  logic              r_ram_we,       w_ram_we_nxt;
  logic              r_p1,           w_p1_nxt;
  logic              r_p1_last,      w_p1_last_nxt;

  logic              w_p2_last;
  logic              w_rd_valid;
  logic              w_rd_last;
  logic [DATA_W-1:0] w_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_cnt         <= '0;
      r_ram_address <= '0;
      r_ram_data_in <= '0;
      r_ram_we      <= 1'b0;
      r_p1          <= 1'b0;
      r_p1_last     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_addr        <= w_addr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_ram_address <= w_ram_address_nxt;
      r_ram_data_in <= w_ram_data_in_nxt;
      r_ram_we      <= w_ram_we_nxt;
      r_p1          <= w_p1_nxt;
      r_p1_last     <= w_p1_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_addr_nxt        = r_addr;
    w_cnt_nxt         = r_cnt;
    w_ram_address_nxt = r_ram_address;
    w_ram_data_in_nxt = r_ram_data_in;
    w_ram_we_nxt      = 1'b0;
    w_p1_nxt          = 1'b0;
    w_p1_last_nxt     = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (host.req_valid) begin
          w_addr_nxt = host.req_addr;
          w_cnt_nxt  = host.req_len;
          if (host.req_write) begin
            w_state_nxt = WRITE;
          end else begin
            // Beat 0 is issued on the accept edge itself.
            w_ram_address_nxt = host.req_addr;
            w_p1_nxt          = 1'b1;
            w_p1_last_nxt     = (host.req_len == '0);
            w_state_nxt       = (host.req_len == '0) ? DRAIN : READ;
          end
        end
      end
      WRITE: begin
        if (host.wr_valid) begin
          w_ram_address_nxt = r_addr;
          w_ram_data_in_nxt = host.wr_data;
          w_ram_we_nxt      = 1'b1;
          w_addr_nxt        = r_addr + 1'b1;
          w_cnt_nxt         = r_cnt - 1'b1;
          if (r_cnt == '0) w_state_nxt = IDLE;
        end
      end
      READ: begin
        w_ram_address_nxt = r_addr + 1'b1;
        w_addr_nxt        = r_addr + 1'b1;
        w_cnt_nxt         = r_cnt - 1'b1;
        w_p1_nxt          = 1'b1;
        if (r_cnt == ADDR_W'(1)) begin
          w_p1_last_nxt = 1'b1;
          w_state_nxt   = DRAIN;
        end
      end
      DRAIN: begin
        // Leave on the edge that presents rd_last, so req_ready rises with it.
        if (w_p2_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  ram_rd_pipe #(.DATA_W(DATA_W)) u_rd_pipe (
    .clk        (clk),
    .rst        (rst),
    .i_p1       (r_p1),
    .i_p1_last  (r_p1_last),
    .i_ram_data (ram_data_out),
    .o_p2_last  (w_p2_last),
    .o_rd_valid (w_rd_valid),
    .o_rd_last  (w_rd_last),
    .o_rd_data  (w_rd_data)
  );

  assign host.req_ready = (r_state == IDLE);
  assign host.wr_ready  = (r_state == WRITE);
  assign host.busy      = (r_state != IDLE);
  assign host.rd_valid  = w_rd_valid;
  assign host.rd_last   = w_rd_last;
  assign host.rd_data   = w_rd_data;

  assign ram_address      = r_ram_address;
  assign ram_data_in      = r_ram_data_in;
  assign ram_write_enable = r_ram_we;

endmodule
